// File: rtl/memoria_bist.sv
// Memory BIST master: writes addr^seed to every word, reads it back through a
// RD_LAT-deep tracking pipeline, and reports error count, first failing address and pass.
module memoria_bist #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    output logic              wea,
    input  logic [DATA_W-1:0] dout
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    localparam int unsigned     LAST       = RD_LAT - 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W:0]   ERR_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]        DRAIN_END = 2'(RD_LAT - 1);

    // Address zero-extended or truncated to DATA_W, then XORed with the seed.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
        logic [ADDR_W+DATA_W-1:0] ext;
        ext = {{DATA_W{1'b0}}, a};
        return ext[DATA_W-1:0] ^ s;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [1:0]        drain_q, drain_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] fail_q, fail_d;
    logic              pass_q, pass_d;
    logic              start_q;
    logic              busy_q, done_q, wea_q;
    logic [DATA_W-1:0] din_q;

    logic [RD_LAT-1:0]             pipe_vld_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_q;
    logic [RD_LAT-1:0][DATA_W-1:0] pipe_exp_q;

    logic start_acc;
    logic mismatch;

    // A held start launches only one run: a new request needs a fresh rising edge.
    assign start_acc = start & ~start_q;
    assign mismatch  = pipe_vld_q[LAST] && (dout != pipe_exp_q[LAST]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        seed_d  = seed_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = WRITE;
                    addr_d  = '0;
                    seed_d  = seed;
                end
            end
            WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = READ;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            READ: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_END) begin
                    state_d = FIN;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d  = err_q;
        fail_d = fail_q;
        pass_d = pass_q;
        if (state_q == IDLE && start_acc) begin
            err_d  = '0;
            fail_d = '0;
            pass_d = 1'b0;
        end else if (mismatch) begin
            if (err_q == '0) begin
                fail_d = pipe_addr_q[LAST];
            end
            if (err_q != ERR_MAX) begin
                err_d = err_q + (ADDR_W+1)'(1);
            end
        end
        // The last compare lands on the same edge that enters FIN.
        if (state_q == DRAIN && state_d == FIN) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            seed_q  <= '0;
            drain_q <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wea_q   <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            seed_q  <= seed_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            start_q <= start;
            busy_q  <= (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
            done_q  <= (state_d == FIN);
            wea_q   <= (state_d == WRITE);
            din_q   <= (state_d == WRITE) ? pattern(addr_d, seed_d) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= '0;
            pipe_addr_q <= '0;
            pipe_exp_q  <= '0;
        end else begin
            pipe_vld_q[0]  <= (state_q == READ);
            pipe_addr_q[0] <= addr_q;
            pipe_exp_q[0]  <= pattern(addr_q, seed_q);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_q;
    assign addr      = addr_q;
    assign din       = din_q;
    assign wea       = wea_q;

endmodule
